dpram_arbiter: RTL and testbench

DPRAM_ARBITER -- requirements
Module: dpram_arbiter

---
 rtl/dpram_arbiter_pkg.sv | 25 ++
 rtl/dpram_arbiter_if.sv | 62 ++++++
 rtl/rr_arb2.sv | 47 ++++
 rtl/dpram_arbiter.sv | 154 +++++++++++++++
 tb/tb_dpram_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dpram_arbiter_pkg.sv
// Shared types and constants for the dual-client DPRAM arbiter.
//   state_e     : controller phase (INIT clears the RAM, RUN arbitrates)
//   CLIENT_A/B  : client IDs, also used as bit positions in req/gnt vectors
//   rd_pend_t   : read issued last cycle, waiting for the RAM's registered data
package dpram_arbiter_pkg;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_e;

   localparam logic CLIENT_A = 1'b0;
   localparam logic CLIENT_B = 1'b1;

   typedef struct packed {
      logic valid;
      logic owner;
   } rd_pend_t;

   // One-hot grant vector for a client ID.
   function automatic logic [1:0] client_mask(input logic id);
      return id ? 2'b10 : 2'b01;
   endfunction

endpackage : dpram_arbiter_pkg

// File: rtl/dpram_arbiter_if.sv
// Bundle of client request/grant signals and RAM port signals around the
// DPRAM arbiter.
//   master : client + RAM side (drives requests and ram_data_out)
//   slave  : arbiter side (drives grants, read data/valid, RAM enables)
interface dpram_arbiter_if #(
   parameter int unsigned ram_width = 8,
   parameter int unsigned add_size  = 4
) ();

   // client A
   logic                 a_wr_req;
   logic [add_size-1:0]  a_wr_add;
   logic [ram_width-1:0] a_wr_data;
   logic                 a_wr_gnt;
   logic                 a_rd_req;
   logic [add_size-1:0]  a_rd_add;
   logic                 a_rd_gnt;
   logic                 a_rd_valid;

   // client B
   logic                 b_wr_req;
   logic [add_size-1:0]  b_wr_add;
   logic [ram_width-1:0] b_wr_data;
   logic                 b_wr_gnt;
   logic                 b_rd_req;
   logic [add_size-1:0]  b_rd_add;
   logic                 b_rd_gnt;
   logic                 b_rd_valid;

   // shared read data and status
   logic [ram_width-1:0] rd_data;
   logic                 init_busy;

   // RAM ports
   logic                 ram_write;
   logic                 ram_read;
   logic [add_size-1:0]  ram_write_add;
   logic [add_size-1:0]  ram_read_add;
   logic [ram_width-1:0] ram_data_in;
   logic [ram_width-1:0] ram_data_out;

   modport master (
      output a_wr_req, a_wr_add, a_wr_data, a_rd_req, a_rd_add,
      output b_wr_req, b_wr_add, b_wr_data, b_rd_req, b_rd_add,
      output ram_data_out,
      input  a_wr_gnt, a_rd_gnt, a_rd_valid,
      input  b_wr_gnt, b_rd_gnt, b_rd_valid,
      input  rd_data, init_busy,
      input  ram_write, ram_read, ram_write_add, ram_read_add, ram_data_in
   );

   modport slave (
      input  a_wr_req, a_wr_add, a_wr_data, a_rd_req, a_rd_add,
      input  b_wr_req, b_wr_add, b_wr_data, b_rd_req, b_rd_add,
      input  ram_data_out,
      output a_wr_gnt, a_rd_gnt, a_rd_valid,
      output b_wr_gnt, b_rd_gnt, b_rd_valid,
      output rd_data, init_busy,
      output ram_write, ram_read, ram_write_add, ram_read_add, ram_data_in
   );

endinterface : dpram_arbiter_if

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with a 1-bit last-winner register.
// Ports:
//   clk, rst : clock, asynchronous active-low reset
//   en       : arbitration enable; no grant and no history update when low
//   req[1:0] : requests, bit CLIENT_A / CLIENT_B
//   gnt[1:0] : one-hot grant, combinational in the request cycle
// A lone requester always wins; on contention the client that did not win
// last time wins. History resets to CLIENT_B so A wins the first contention.
module rr_arb2
   import dpram_arbiter_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   logic last_q;
   logic last_d;
   logic winner_c;

   // Winner selection and history update.
   always_comb begin
      gnt      = 2'b00;
      last_d   = last_q;
      winner_c = CLIENT_A;
      if (en && (req != 2'b00)) begin
         if (req == 2'b11) begin
            winner_c = ~last_q;
         end else begin
            winner_c = req[CLIENT_B] ? CLIENT_B : CLIENT_A;
         end
         gnt    = client_mask(winner_c);
         last_d = winner_c;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_q <= CLIENT_B;
      end else begin
         last_q <= last_d;
      end
   end

endmodule : rr_arb2

// File: rtl/dpram_arbiter.sv
// Arbiter sharing one dual-port RAM (separate write and read ports) between
// two clients A and B.
// Ports:
//   clk   : clock, all state on the rising edge
//   rst   : asynchronous active-low reset; while low every output is 0
//   bus   : dpram_arbiter_if.slave
//           client write req/add/data -> wr_gnt (same cycle)
//           client read req/add       -> rd_gnt (same cycle),
//                                        rd_valid + rd_data one cycle later
//           RAM write/read enables, addresses, write data; ram_data_out in
//           init_busy high while the RAM is being cleared after reset
// After reset release the block spends ram_depth cycles writing zero to every
// RAM word (INIT), then arbitrates the write and read ports independently
// (RUN). A read and a write to the same address in one cycle return the old
// data; there is no forwarding.
module dpram_arbiter
   import dpram_arbiter_pkg::*;
#(
   parameter int unsigned ram_width = 8,
   parameter int unsigned ram_depth = 16,
   parameter int unsigned add_size  = 4
) (
   input  logic             clk,
   input  logic             rst,
   dpram_arbiter_if.slave   bus
);

   localparam logic [add_size-1:0] LAST_ADD = add_size'(ram_depth - 1);

   state_e              state_q;
   state_e              state_d;
   logic [add_size-1:0] init_cnt_q;
   logic [add_size-1:0] init_cnt_d;
   rd_pend_t            rd_pend_q;
   rd_pend_t            rd_pend_d;

   logic                 arb_en_c;
   logic [1:0]           wr_req_c;
   logic [1:0]           rd_req_c;
   logic [1:0]           wr_gnt_c;
   logic [1:0]           rd_gnt_c;
   logic                 ram_write_c;
   logic                 ram_read_c;
   logic [add_size-1:0]  ram_write_add_c;
   logic [add_size-1:0]  ram_read_add_c;
   logic [ram_width-1:0] ram_data_in_c;
   logic                 init_busy_c;

   // Arbiters only act in RUN and never while reset is asserted.
   assign arb_en_c = rst && (state_q == RUN);
   assign wr_req_c = {bus.b_wr_req, bus.a_wr_req};
   assign rd_req_c = {bus.b_rd_req, bus.a_rd_req};

   rr_arb2 u_wr_arb (
      .clk (clk),
      .rst (rst),
      .en  (arb_en_c),
      .req (wr_req_c),
      .gnt (wr_gnt_c)
   );

   rr_arb2 u_rd_arb (
      .clk (clk),
      .rst (rst),
      .en  (arb_en_c),
      .req (rd_req_c),
      .gnt (rd_gnt_c)
   );

   // Next-state and RAM port muxing. Everything is gated by rst so the
   // outputs drop to zero the moment reset asserts, not at the next edge.
   always_comb begin
      state_d         = state_q;
      init_cnt_d      = init_cnt_q;
      rd_pend_d       = '0;
      ram_write_c     = 1'b0;
      ram_read_c      = 1'b0;
      ram_write_add_c = '0;
      ram_read_add_c  = '0;
      ram_data_in_c   = '0;
      init_busy_c     = 1'b0;

      if (rst) begin
         unique case (state_q)
            INIT: begin
               init_busy_c     = 1'b1;
               ram_write_c     = 1'b1;
               ram_write_add_c = init_cnt_q;
               init_cnt_d      = init_cnt_q + 1'b1;
               if (init_cnt_q == LAST_ADD) begin
                  state_d    = RUN;
                  init_cnt_d = '0;
               end
            end
            RUN: begin
               if (wr_gnt_c[CLIENT_A]) begin
                  ram_write_c     = 1'b1;
                  ram_write_add_c = bus.a_wr_add;
                  ram_data_in_c   = bus.a_wr_data;
               end else if (wr_gnt_c[CLIENT_B]) begin
                  ram_write_c     = 1'b1;
                  ram_write_add_c = bus.b_wr_add;
                  ram_data_in_c   = bus.b_wr_data;
               end

               if (rd_gnt_c[CLIENT_A]) begin
                  ram_read_c     = 1'b1;
                  ram_read_add_c = bus.a_rd_add;
               end else if (rd_gnt_c[CLIENT_B]) begin
                  ram_read_c     = 1'b1;
                  ram_read_add_c = bus.b_rd_add;
               end

               // Remember who owns the RAM data arriving next cycle.
               rd_pend_d.valid = |rd_gnt_c;
               rd_pend_d.owner = rd_gnt_c[CLIENT_B];
            end
            default: begin
               state_d = INIT;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= INIT;
         init_cnt_q <= '0;
         rd_pend_q  <= '0;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
         rd_pend_q  <= rd_pend_d;
      end
   end

   // Client-facing outputs.
   assign bus.a_wr_gnt   = wr_gnt_c[CLIENT_A];
   assign bus.b_wr_gnt   = wr_gnt_c[CLIENT_B];
   assign bus.a_rd_gnt   = rd_gnt_c[CLIENT_A];
   assign bus.b_rd_gnt   = rd_gnt_c[CLIENT_B];
   assign bus.a_rd_valid = rd_pend_q.valid && (rd_pend_q.owner == CLIENT_A);
   assign bus.b_rd_valid = rd_pend_q.valid && (rd_pend_q.owner == CLIENT_B);
   assign bus.rd_data    = rd_pend_q.valid ? bus.ram_data_out : '0;
   assign bus.init_busy  = init_busy_c;

   // RAM-facing outputs.
   assign bus.ram_write     = ram_write_c;
   assign bus.ram_read      = ram_read_c;
   assign bus.ram_write_add = ram_write_add_c;
   assign bus.ram_read_add  = ram_read_add_c;
   assign bus.ram_data_in   = ram_data_in_c;

endmodule : dpram_arbiter

// File: tb/tb_dpram_arbiter.sv
// Testbench for dpram_arbiter: behavioural RAM, a reference model of memory
// contents / fairness / read latency, directed scenarios and random traffic.
module tb_dpram_arbiter;

   localparam int unsigned DW    = 8;
   localparam int unsigned AW    = 4;
   localparam int unsigned DEPTH = 16;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   dpram_arbiter_if #(.ram_width(DW), .add_size(AW)) bus ();

   dpram_arbiter #(
      .ram_width (DW),
      .ram_depth (DEPTH),
      .add_size  (AW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Behavioural RAM: registered read, old data on same-address read/write.
   logic [DW-1:0] ram [DEPTH];
   always @(posedge clk) begin
      if (bus.ram_write) ram[bus.ram_write_add] <= bus.ram_data_in;
      if (bus.ram_read)  bus.ram_data_out <= ram[bus.ram_read_add];
   end

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state.
   bit            m_run;
   int            m_cnt;
   logic [DW-1:0] m_mem [DEPTH];
   bit            m_last_wr;   // 0 = A, 1 = B
   bit            m_last_rd;
   bit            m_pv;
   bit            m_po;
   logic [DW-1:0] m_pd;
   bit            auto_mode;

   // Observations taken mid-cycle by step().
   logic          o_awg, o_bwg, o_arg, o_brg, o_arv, o_brv, o_busy;
   logic [AW-1:0] o_wadd;
   logic [DW-1:0] o_rd;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic clear_reqs();
      bus.a_wr_req = 1'b0; bus.a_wr_add = '0; bus.a_wr_data = '0;
      bus.b_wr_req = 1'b0; bus.b_wr_add = '0; bus.b_wr_data = '0;
      bus.a_rd_req = 1'b0; bus.a_rd_add = '0;
      bus.b_rd_req = 1'b0; bus.b_rd_add = '0;
   endtask

   task automatic set_wr(input bit cl, input logic [AW-1:0] ad, input logic [DW-1:0] dt);
      if (!cl) begin bus.a_wr_req = 1'b1; bus.a_wr_add = ad; bus.a_wr_data = dt; end
      else     begin bus.b_wr_req = 1'b1; bus.b_wr_add = ad; bus.b_wr_data = dt; end
   endtask

   task automatic set_rd(input bit cl, input logic [AW-1:0] ad);
      if (!cl) begin bus.a_rd_req = 1'b1; bus.a_rd_add = ad; end
      else     begin bus.b_rd_req = 1'b1; bus.b_rd_add = ad; end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_ctrl"},
          32'({bus.a_wr_gnt, bus.b_wr_gnt, bus.a_rd_gnt, bus.b_rd_gnt,
               bus.a_rd_valid, bus.b_rd_valid, bus.ram_write, bus.ram_read,
               bus.init_busy}), 32'd0);
      chk({tag, "_bus"},
          32'({bus.ram_write_add, bus.ram_read_add, bus.ram_data_in, bus.rd_data}),
          32'd0);
   endtask

   // Assert reset off-edge, check outputs clear at once and stay clear,
   // release just after a rising edge and reset the model.
   task automatic do_reset();
      clear_reqs();
      rst = 1'b0;
      #1;
      check_zero("rst_now");
      repeat (2) begin
         @(negedge clk);
         check_zero("rst_hold");
      end
      @(posedge clk);
      #1;
      rst       = 1'b1;
      m_run     = 1'b0;
      m_cnt     = 0;
      m_last_wr = 1'b1;
      m_last_rd = 1'b1;
      m_pv      = 1'b0;
   endtask

   // One clock cycle: compare against the model mid-cycle, advance the model,
   // then (in random mode) refresh requests that were granted or idle.
   task automatic step();
      bit ewa, ewb, era, erb;
      @(negedge clk);
      o_awg = bus.a_wr_gnt; o_bwg = bus.b_wr_gnt;
      o_arg = bus.a_rd_gnt; o_brg = bus.b_rd_gnt;
      o_arv = bus.a_rd_valid; o_brv = bus.b_rd_valid;
      o_busy = bus.init_busy; o_wadd = bus.ram_write_add; o_rd = bus.rd_data;

      ewa = 0; ewb = 0; era = 0; erb = 0;
      if (m_run) begin
         if (bus.a_wr_req && bus.b_wr_req) begin ewa = m_last_wr; ewb = !m_last_wr; end
         else begin ewa = bus.a_wr_req; ewb = bus.b_wr_req; end
         if (bus.a_rd_req && bus.b_rd_req) begin era = m_last_rd; erb = !m_last_rd; end
         else begin era = bus.a_rd_req; erb = bus.b_rd_req; end
      end

      chk("a_wr_gnt", o_awg, ewa);
      chk("b_wr_gnt", o_bwg, ewb);
      chk("a_rd_gnt", o_arg, era);
      chk("b_rd_gnt", o_brg, erb);
      chk("init_busy", o_busy, !m_run);
      if (!m_run) begin
         chk("init_write", bus.ram_write, 1);
         chk("init_add", o_wadd, 32'(m_cnt));
         chk("init_data", bus.ram_data_in, 0);
      end else begin
         chk("ram_write", bus.ram_write, ewa | ewb);
         if (ewa) begin
            chk("wr_add_a", o_wadd, bus.a_wr_add);
            chk("wr_data_a", bus.ram_data_in, bus.a_wr_data);
         end else if (ewb) begin
            chk("wr_add_b", o_wadd, bus.b_wr_add);
            chk("wr_data_b", bus.ram_data_in, bus.b_wr_data);
         end
      end
      chk("ram_read", bus.ram_read, era | erb);
      if (era) chk("rd_add_a", bus.ram_read_add, bus.a_rd_add);
      else if (erb) chk("rd_add_b", bus.ram_read_add, bus.b_rd_add);
      chk("a_rd_valid", o_arv, m_pv && !m_po);
      chk("b_rd_valid", o_brv, m_pv && m_po);
      if (m_pv) chk("rd_data", o_rd, m_pd);

      if (!m_run) begin
         m_mem[m_cnt] = '0;
         m_cnt++;
         if (m_cnt == DEPTH) m_run = 1'b1;
         m_pv = 1'b0;
      end else begin
         m_pv = era | erb;
         m_po = erb;
         m_pd = era ? m_mem[bus.a_rd_add] : (erb ? m_mem[bus.b_rd_add] : '0);
         if (ewa) m_mem[bus.a_wr_add] = bus.a_wr_data;
         else if (ewb) m_mem[bus.b_wr_add] = bus.b_wr_data;
         if (ewa | ewb) m_last_wr = ewb;
         if (era | erb) m_last_rd = erb;
      end

      @(posedge clk);
      #1;
      if (auto_mode) begin
         if (o_awg || !bus.a_wr_req) begin
            bus.a_wr_req = ($urandom_range(0, 99) < 60);
            bus.a_wr_add = AW'($urandom); bus.a_wr_data = DW'($urandom);
         end
         if (o_bwg || !bus.b_wr_req) begin
            bus.b_wr_req = ($urandom_range(0, 99) < 60);
            bus.b_wr_add = AW'($urandom); bus.b_wr_data = DW'($urandom);
         end
         if (o_arg || !bus.a_rd_req) begin
            bus.a_rd_req = ($urandom_range(0, 99) < 60);
            bus.a_rd_add = AW'($urandom);
         end
         if (o_brg || !bus.b_rd_req) begin
            bus.b_rd_req = ($urandom_range(0, 99) < 60);
            bus.b_rd_add = AW'($urandom);
         end
      end
   endtask

   initial begin
      int lat;
      rst       = 1'b1;
      auto_mode = 1'b0;
      clear_reqs();
      #2;
      do_reset();

      // RAM clear after reset, then idle RUN.
      repeat (DEPTH) step();
      step();
      chk("init_done", o_busy, 0);

      // Simultaneous writes: A first, then B; read both back.
      set_wr(0, 4'd3, 8'hAA);
      set_wr(1, 4'd5, 8'h55);
      step();
      chk("wc1_a", o_awg, 1);
      chk("wc1_b", o_bwg, 0);
      bus.a_wr_req = 1'b0;
      step();
      chk("wc2_b", o_bwg, 1);
      bus.b_wr_req = 1'b0;
      set_rd(0, 4'd3);
      step();
      bus.a_rd_req = 1'b0;
      set_rd(1, 4'd5);
      step();
      chk("rd3_valid", o_arv, 1);
      chk("rd3_data", o_rd, 8'hAA);
      bus.b_rd_req = 1'b0;
      step();
      chk("rd5_valid", o_brv, 1);
      chk("rd5_data", o_rd, 8'h55);

      // Continuous read contention alternates A,B,A,B.
      set_rd(0, 4'd3);
      set_rd(1, 4'd5);
      for (int k = 0; k < 4; k++) begin
         step();
         chk("rr_a_gnt", o_arg, 32'(k % 2 == 0));
         chk("rr_b_gnt", o_brg, 32'(k % 2 == 1));
         if (k > 0) begin
            chk("rr_a_valid", o_arv, 32'((k - 1) % 2 == 0));
            chk("rr_data", o_rd, ((k - 1) % 2 == 0) ? 32'hAA : 32'h55);
         end
      end
      bus.a_rd_req = 1'b0;
      bus.b_rd_req = 1'b0;
      step();
      chk("rr_tail_valid", o_brv, 1);
      chk("rr_tail_data", o_rd, 8'h55);

      // Same-address read and write in one cycle returns old data.
      set_wr(0, 4'd7, 8'h22);
      step();
      set_wr(0, 4'd7, 8'h11);
      set_rd(1, 4'd7);
      step();
      chk("raw_wgnt", o_awg, 1);
      chk("raw_rgnt", o_brg, 1);
      clear_reqs();
      step();
      chk("raw_old", o_rd, 8'h22);
      set_rd(1, 4'd7);
      step();
      clear_reqs();
      step();
      chk("raw_new", o_rd, 8'h11);

      // Random traffic.
      auto_mode = 1'b1;
      repeat (300) step();
      auto_mode = 1'b0;
      clear_reqs();
      repeat (2) step();

      // Reset the cycle after a read grant: data dropped, INIT restarts.
      set_rd(0, 4'd2);
      step();
      chk("rst_rd_gnt", o_arg, 1);
      do_reset();
      step();
      chk("reinit_busy", o_busy, 1);
      chk("reinit_add", o_wadd, 0);
      chk("reinit_no_valid", o_arv, 0);
      repeat (DEPTH - 1) step();

      // Write held through INIT is granted in the first RUN cycle.
      do_reset();
      set_wr(0, 4'd9, 8'h5A);
      lat = -1;
      for (int i = 0; i < DEPTH + 4; i++) begin
         step();
         if (o_awg) begin
            lat = i;
            break;
         end
      end
      chk("init_wr_lat", lat, DEPTH);
      clear_reqs();
      set_rd(1, 4'd9);
      step();
      clear_reqs();
      step();
      chk("post_init_rd", o_rd, 8'h5A);

      auto_mode = 1'b1;
      repeat (100) step();
      auto_mode = 1'b0;
      clear_reqs();
      repeat (2) step();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule : tb_dpram_arbiter
